// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Package : loader_pkg
// Brief   : Frame constants and FSM state encoding for the UART program loader.
// Rev     : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam logic [7:0] SYNC      = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;
    localparam logic [7:0] ACK       = 8'h06;
    localparam logic [7:0] NAK       = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_AHI  = 3'd2,
        ST_ALO  = 3'd3,
        ST_LEN  = 3'd4,
        ST_DATA = 3'd5,
        ST_CHK  = 3'd6,
        ST_RESP = 3'd7
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/loader_timeout.sv
`default_nettype none
// ============================================================================
// Module : loader_timeout
// Brief  : Reloadable down-counter; expired is high once TIMEOUT_CYCLES
//          cycles have passed without a load.
// Rev    : 1.0 - initial release
// ============================================================================
module loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1_250_000
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic expired
);

    localparam int unsigned COUNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [COUNT_W-1:0] r_count_q;
    logic [COUNT_W-1:0] w_count_d;

    // Holds at zero so expiry stays asserted until the next load.
    always_comb begin
        w_count_d = r_count_q;
        if (load) begin
            w_count_d = COUNT_W'(TIMEOUT_CYCLES);
        end else if (r_count_q != '0) begin
            w_count_d = r_count_q - COUNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count_q <= COUNT_W'(TIMEOUT_CYCLES);
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign expired = (r_count_q == '0);

endmodule
`default_nettype wire

// File: rtl/uart_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module : uart_loader_ctrl
// Brief  : Parses host loader frames from the UART byte stream, writes payload
//          into program memory and answers each frame with ACK or NAK.
// Rev    : 1.0 - initial release
// ============================================================================
module uart_loader_ctrl
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1_250_000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            read_data,
    input  logic                  read_data_available,
    output logic [7:0]            write_data,
    output logic                  write_data_enable,
    input  logic                  write_data_available,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  run,
    output logic [7:0]            nak_count
);

    loader_state_t         r_state_q, w_state_d;
    logic [7:0]            r_cmd_q, w_cmd_d;
    logic [7:0]            r_addr_hi_q, w_addr_hi_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, w_addr_d;
    logic [8:0]            r_count_q, w_count_d;
    logic [7:0]            r_sum_q, w_sum_d;
    logic [7:0]            r_write_data_q, w_write_data_d;
    logic                  r_write_data_enable_q, w_write_data_enable_d;
    logic [ADDR_WIDTH-1:0] r_mem_addr_q, w_mem_addr_d;
    logic [7:0]            r_mem_wdata_q, w_mem_wdata_d;
    logic                  r_mem_we_q, w_mem_we_d;
    logic                  r_busy_q, w_busy_d;
    logic                  r_run_q, w_run_d;
    logic [7:0]            r_nak_count_q, w_nak_count_d;

    logic [7:0] w_sum_next;
    logic       w_tmo_load;
    logic       w_tmo_expired;

    // Only the frame-body states are timed; everywhere else the counter is parked.
    assign w_tmo_load = (r_state_q == ST_IDLE) || (r_state_q == ST_RESP) || read_data_available;

    loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .load    (w_tmo_load),
        .expired (w_tmo_expired)
    );

    assign w_sum_next = r_sum_q + read_data;

    always_comb begin
        w_state_d             = r_state_q;
        w_cmd_d               = r_cmd_q;
        w_addr_hi_d           = r_addr_hi_q;
        w_addr_d              = r_addr_q;
        w_count_d             = r_count_q;
        w_sum_d               = r_sum_q;
        w_write_data_d        = r_write_data_q;
        w_write_data_enable_d = 1'b0;
        w_mem_addr_d          = r_mem_addr_q;
        w_mem_wdata_d         = r_mem_wdata_q;
        w_mem_we_d            = 1'b0;
        w_run_d               = r_run_q;
        w_nak_count_d         = r_nak_count_q;

        unique case (r_state_q)
            ST_IDLE: begin
                if (read_data_available && (read_data == SYNC)) begin
                    w_state_d = ST_CMD;
                end
            end
            ST_RESP: begin
                if (write_data_available) begin
                    w_write_data_enable_d = 1'b1;
                    w_state_d             = ST_IDLE;
                    if ((r_write_data_q == ACK) && (r_cmd_q == CMD_RUN)) begin
                        w_run_d = 1'b1;
                    end
                    if ((r_write_data_q != ACK) && (r_nak_count_q != 8'hFF)) begin
                        w_nak_count_d = r_nak_count_q + 8'd1;
                    end
                end
            end
            default: begin
                // A byte strobe takes priority over a coincident expiry.
                if (read_data_available) begin
                    unique case (r_state_q)
                        ST_CMD: begin
                            w_cmd_d   = read_data;
                            w_sum_d   = read_data;
                            w_state_d = ST_AHI;
                        end
                        ST_AHI: begin
                            w_addr_hi_d = read_data;
                            w_sum_d     = w_sum_next;
                            w_state_d   = ST_ALO;
                        end
                        ST_ALO: begin
                            w_addr_d  = ADDR_WIDTH'({r_addr_hi_q, read_data});
                            w_sum_d   = w_sum_next;
                            w_state_d = ST_LEN;
                        end
                        ST_LEN: begin
                            w_count_d = (read_data == 8'h00) ? 9'd256 : {1'b0, read_data};
                            w_sum_d   = w_sum_next;
                            w_state_d = (r_cmd_q == CMD_WRITE) ? ST_DATA : ST_CHK;
                        end
                        ST_DATA: begin
                            w_mem_we_d    = 1'b1;
                            w_mem_addr_d  = r_addr_q;
                            w_mem_wdata_d = read_data;
                            w_addr_d      = r_addr_q + ADDR_WIDTH'(1);
                            w_count_d     = r_count_q - 9'd1;
                            w_sum_d       = w_sum_next;
                            if (r_count_q == 9'd1) begin
                                w_state_d = ST_CHK;
                            end
                        end
                        ST_CHK: begin
                            w_write_data_d = ((w_sum_next == 8'h00) &&
                                              ((r_cmd_q == CMD_WRITE) || (r_cmd_q == CMD_RUN)))
                                             ? ACK : NAK;
                            w_state_d      = ST_RESP;
                        end
                        default: begin
                        end
                    endcase
                end else if (w_tmo_expired) begin
                    w_write_data_d = NAK;
                    w_state_d      = ST_RESP;
                end
            end
        endcase

        w_busy_d = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q             <= ST_IDLE;
            r_cmd_q               <= 8'h00;
            r_addr_hi_q           <= 8'h00;
            r_addr_q              <= '0;
            r_count_q             <= 9'd0;
            r_sum_q               <= 8'h00;
            r_write_data_q        <= 8'h00;
            r_write_data_enable_q <= 1'b0;
            r_mem_addr_q          <= '0;
            r_mem_wdata_q         <= 8'h00;
            r_mem_we_q            <= 1'b0;
            r_busy_q              <= 1'b0;
            r_run_q               <= 1'b0;
            r_nak_count_q         <= 8'h00;
        end else begin
            r_state_q             <= w_state_d;
            r_cmd_q               <= w_cmd_d;
            r_addr_hi_q           <= w_addr_hi_d;
            r_addr_q              <= w_addr_d;
            r_count_q             <= w_count_d;
            r_sum_q               <= w_sum_d;
            r_write_data_q        <= w_write_data_d;
            r_write_data_enable_q <= w_write_data_enable_d;
            r_mem_addr_q          <= w_mem_addr_d;
            r_mem_wdata_q         <= w_mem_wdata_d;
            r_mem_we_q            <= w_mem_we_d;
            r_busy_q              <= w_busy_d;
            r_run_q               <= w_run_d;
            r_nak_count_q         <= w_nak_count_d;
        end
    end

    assign write_data        = r_write_data_q;
    assign write_data_enable = r_write_data_enable_q;
    assign mem_addr          = r_mem_addr_q;
    assign mem_wdata         = r_mem_wdata_q;
    assign mem_we            = r_mem_we_q;
    assign busy              = r_busy_q;
    assign run               = r_run_q;
    assign nak_count         = r_nak_count_q;

endmodule
`default_nettype wire
